// File: rtl/mmu_pkg.sv
// Shared MMU types: walker <-> dmem request/response bundles,
// dmem command encodings and the PTE-read responder state set.
package mmu_pkg;

    localparam int SIZE_VADDR = 39;

    // Command / access-type encodings shared by walker and responder
    localparam logic [4:0] M_XRD = 5'b00000;
    localparam logic [3:0] MT_D  = 4'b0011;

    typedef struct packed {
        logic                valid;
        logic [SIZE_VADDR:0] addr;
        logic [4:0]          cmd;
        logic [3:0]          typ;
        logic                kill;
        logic                phys;
        logic [63:0]         data;
    } ptw_dmem_req_t;

    typedef struct packed {
        ptw_dmem_req_t req;
    } ptw_dmem_comm_t;

    typedef struct packed {
        logic        valid;
        logic        nack;
        logic [63:0] data;
    } dmem_ptw_resp_t;

    typedef struct packed {
        logic           dmem_ready;
        dmem_ptw_resp_t resp;
    } dmem_ptw_comm_t;

    typedef enum logic [2:0] {
        PR_IDLE  = 3'd0,
        PR_ISSUE = 3'd1,
        PR_WAIT  = 3'd2,
        PR_RESP  = 3'd3,
        PR_NACK  = 3'd4
    } ptw_resp_state_t;

    // Only aligned, physical, doubleword reads are serviced
    function automatic logic is_pte_read(
        input ptw_dmem_req_t r
    );
        return (r.cmd == M_XRD) &&
               (r.typ == MT_D) &&
               r.phys &&
               (r.addr[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/ptw_dmem_responder.sv
// PTW dmem responder: forwards one PTE read at a time to memory.
// Ports: walker req/resp structs, mem_req/addr/gnt/rvalid/rdata/err.
module ptw_dmem_responder
    import mmu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MEM_ADDR_W     = SIZE_VADDR + 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  ptw_dmem_comm_t        ptw_dmem_comm_i,
    output dmem_ptw_comm_t        dmem_ptw_comm_o,
    output logic                  mem_req_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [63:0]           mem_rdata_i,
    input  logic                  mem_err_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    ptw_resp_state_t       r_state;
    ptw_resp_state_t       w_state_nxt;
    logic                  r_stale;
    logic [CNT_W-1:0]      r_cnt;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [63:0]           r_data;

    ptw_dmem_req_t w_req;
    logic          w_legal;
    logic          w_issue;
    logic          w_rv_live;
    logic          w_timeout;
    logic          w_stale_set;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_latch_addr;
    logic          w_latch_data;
    logic          w_unused_wdata;

    assign w_req          = ptw_dmem_comm_i.req;
    assign w_legal        = is_pte_read(w_req);
    assign w_unused_wdata = ^w_req.data;

    // A stale transaction must drain before a new one goes out
    assign w_issue   = (r_state == PR_ISSUE) && !r_stale;
    // rvalid while stale belongs to the abandoned transaction
    assign w_rv_live = mem_rvalid_i && !r_stale;
    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= PR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_stale_set     = 1'b0;
        w_cnt_clr       = 1'b0;
        w_cnt_inc       = 1'b0;
        w_latch_addr    = 1'b0;
        w_latch_data    = 1'b0;
        dmem_ptw_comm_o = '0;
        mem_req_o       = 1'b0;
        mem_addr_o      = '0;

        unique case (r_state)
            PR_IDLE: begin
                dmem_ptw_comm_o.dmem_ready = 1'b1;
                if (w_req.valid) begin
                    w_latch_addr = 1'b1;
                    w_state_nxt  = w_legal ? PR_ISSUE
                                           : PR_NACK;
                end
            end
            PR_ISSUE: begin
                mem_req_o  = w_issue;
                mem_addr_o = r_addr;
                if (w_issue && mem_gnt_i) begin
                    w_cnt_clr = 1'b1;
                    if (w_req.kill) begin
                        // granted but abandoned: data still owed
                        w_stale_set = 1'b1;
                        w_state_nxt = PR_IDLE;
                    end else begin
                        w_state_nxt = PR_WAIT;
                    end
                end else if (w_req.kill) begin
                    w_state_nxt = PR_IDLE;
                end
            end
            PR_WAIT: begin
                w_cnt_inc = 1'b1;
                // data arriving beats both kill and timeout
                if (w_rv_live) begin
                    if (w_req.kill) begin
                        w_state_nxt = PR_IDLE;
                    end else if (mem_err_i) begin
                        w_state_nxt = PR_NACK;
                    end else begin
                        w_latch_data = 1'b1;
                        w_state_nxt  = PR_RESP;
                    end
                end else if (w_req.kill) begin
                    w_stale_set = 1'b1;
                    w_state_nxt = PR_IDLE;
                end else if (w_timeout) begin
                    w_stale_set = 1'b1;
                    w_state_nxt = PR_NACK;
                end
            end
            PR_RESP: begin
                dmem_ptw_comm_o.resp.valid = 1'b1;
                dmem_ptw_comm_o.resp.data  = r_data;
                w_state_nxt = PR_IDLE;
            end
            PR_NACK: begin
                dmem_ptw_comm_o.resp.nack = 1'b1;
                w_state_nxt = PR_IDLE;
            end
            default: begin
                w_state_nxt = PR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_stale <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (w_stale_set) begin
                r_stale <= 1'b1;
            end else if (r_stale && mem_rvalid_i) begin
                r_stale <= 1'b0;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_latch_addr) begin
                r_addr <= MEM_ADDR_W'(w_req.addr);
            end
            if (w_latch_data) begin
                r_data <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_ptw_dmem_responder.sv
// Scoreboard bench for ptw_dmem_responder: directed walker
// requests, scripted memory side, monitor checks responses.
module tb_ptw_dmem_responder;
    import mmu_pkg::*;

    localparam int TO = 8;

    logic                clk_i = 1'b0;
    logic                rstn_i = 1'b0;
    ptw_dmem_comm_t      req_s;
    dmem_ptw_comm_t      rsp_s;
    logic                mem_req_o;
    logic [SIZE_VADDR:0] mem_addr_o;
    logic                mem_gnt_i;
    logic                mem_rvalid_i;
    logic [63:0]         mem_rdata_i;
    logic                mem_err_i;

    typedef struct {
        logic        nack;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_cnt = 0;
    int   resp_cyc = 0;
    int   req_hi = 0;
    int   acc_cyc = 0;
    int   g_cyc = 0;
    int   r0;
    int   q0;
    logic [SIZE_VADDR:0] a_hold;

    ptw_dmem_responder #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .ptw_dmem_comm_i(req_s),
        .dmem_ptw_comm_o(rsp_s),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (mem_req_o) req_hi++;
        if (rstn_i && (rsp_s.resp.valid || rsp_s.resp.nack)) begin
            exp_t e;
            resp_cnt++;
            resp_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp valid=%0b nack=%0b data=%0h",
                         rsp_s.resp.valid, rsp_s.resp.nack,
                         rsp_s.resp.data);
            end else begin
                e = sb_q.pop_front();
                chk("resp_nack", rsp_s.resp.nack, e.nack);
                chk("resp_valid", rsp_s.resp.valid, !e.nack);
                if (!e.nack) chk("resp_data", rsp_s.resp.data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic nk, input logic [63:0] d);
        exp_t e;
        e.nack = nk;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Present a request in IDLE; returns with DUT one state later
    task automatic accept(input logic [SIZE_VADDR:0] a,
                          input logic [4:0] c,
                          input logic [3:0] t);
        chk("ready_idle", rsp_s.dmem_ready, 1'b1);
        req_s.req.valid = 1'b1;
        req_s.req.addr  = a;
        req_s.req.cmd   = c;
        req_s.req.typ   = t;
        req_s.req.phys  = 1'b1;
        acc_cyc = cyc;
        tick();
        req_s.req.valid = 1'b0;
    endtask

    task automatic mem_rsp(input logic [63:0] d, input logic er);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        mem_err_i    = er;
        tick();
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        req_s        = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_err_i    = 1'b0;
        #2;
        chk("rst_ready", rsp_s.dmem_ready, 1'b1);
        chk("rst_valid", rsp_s.resp.valid, 1'b0);
        chk("rst_nack", rsp_s.resp.nack, 1'b0);
        chk("rst_data", rsp_s.resp.data, 64'h0);
        chk("rst_mreq", mem_req_o, 1'b0);
        chk("rst_maddr", mem_addr_o, 40'h0);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();

        // Basic read, gnt same cycle, rvalid next
        accept(40'h80001008, M_XRD, MT_D);
        chk("b_mreq", mem_req_o, 1'b1);
        chk("b_maddr", mem_addr_o, 40'h80001008);
        chk("b_ready_iss", rsp_s.dmem_ready, 1'b0);
        push(1'b0, 64'h0000_0000_2000_0C01);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("b_ready_wait", rsp_s.dmem_ready, 1'b0);
        chk("b_mreq_wait", mem_req_o, 1'b0);
        mem_rsp(64'h0000_0000_2000_0C01, 1'b0);
        chk("b_valid", rsp_s.resp.valid, 1'b1);
        tick();
        chk("b_latency", resp_cyc, acc_cyc + 3);
        chk("b_pulse", rsp_s.resp.valid, 1'b0);
        chk("b_ready_end", rsp_s.dmem_ready, 1'b1);

        // Grant backpressure for 5 cycles
        accept(40'h80002010, M_XRD, MT_D);
        r0 = resp_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("bp_mreq", mem_req_o, 1'b1);
            chk("bp_maddr", mem_addr_o, 40'h80002010);
            chk("bp_ready", rsp_s.dmem_ready, 1'b0);
            tick();
        end
        chk("bp_noresp", resp_cnt, r0);
        push(1'b0, 64'h1111_2222_3333_4444);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        mem_rsp(64'h1111_2222_3333_4444, 1'b0);
        tick();

        // Illegal command and misaligned address
        q0 = req_hi;
        r0 = resp_cnt;
        push(1'b1, 64'h0);
        accept(40'h80001008, 5'b01010, MT_D);
        chk("ill_cmd_nack", rsp_s.resp.nack, 1'b1);
        tick();
        chk("ill_cmd_pulse", rsp_s.resp.nack, 1'b0);
        push(1'b1, 64'h0);
        accept(40'h80001004, M_XRD, MT_D);
        tick();
        tick();
        chk("ill_nresp", resp_cnt, r0 + 2);
        chk("ill_no_mreq", req_hi, q0);

        // Memory error, then re-issue
        push(1'b1, 64'h0);
        accept(40'h80003000, M_XRD, MT_D);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        mem_rsp(64'hBAD0, 1'b1);
        chk("err_valid0", rsp_s.resp.valid, 1'b0);
        tick();
        push(1'b0, 64'h0000_0000_3000_1C01);
        accept(40'h80003000, M_XRD, MT_D);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        tick();
        tick();
        mem_rsp(64'h0000_0000_3000_1C01, 1'b0);
        tick();

        // Timeout then stale drain
        push(1'b1, 64'h0);
        accept(40'h80004000, M_XRD, MT_D);
        r0 = resp_cnt;
        g_cyc = cyc;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 20 && resp_cnt == r0; i++) tick();
        chk("to_seen", resp_cnt, r0 + 1);
        chk("to_latency", resp_cyc, g_cyc + 9);
        push(1'b0, 64'h0000_0000_0000_BEEF);
        accept(40'h80005000, M_XRD, MT_D);
        for (int i = 0; i < 3; i++) begin
            chk("stale_hold", mem_req_o, 1'b0);
            tick();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD;
        chk("stale_same", mem_req_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        chk("stale_rel", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        mem_rsp(64'h0000_0000_0000_BEEF, 1'b0);
        tick();

        // Kill in ISSUE: no response
        r0 = resp_cnt;
        accept(40'h80006000, M_XRD, MT_D);
        req_s.req.kill = 1'b1;
        tick();
        req_s.req.kill = 1'b0;
        chk("kill_ready", rsp_s.dmem_ready, 1'b1);
        tick();
        tick();
        chk("kill_noresp", resp_cnt, r0);

        // Reset while in WAIT
        accept(40'h80007000, M_XRD, MT_D);
        a_hold = mem_addr_o;
        chk("rw_addr", a_hold, 40'h80007000);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("rw_wait", rsp_s.dmem_ready, 1'b0);
        rstn_i = 1'b0;
        #1;
        chk("rw_ready", rsp_s.dmem_ready, 1'b1);
        chk("rw_mreq", mem_req_o, 1'b0);
        chk("rw_maddr", mem_addr_o, 40'h0);
        chk("rw_valid", rsp_s.resp.valid, 1'b0);
        tick();
        rstn_i = 1'b1;
        tick();
        chk("rw_ready_rel", rsp_s.dmem_ready, 1'b1);

        // Fresh read after reset issues immediately
        push(1'b0, 64'h0000_0000_4000_0001);
        accept(40'h80008008, M_XRD, MT_D);
        chk("pr_mreq", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        mem_rsp(64'h0000_0000_4000_0001, 1'b0);
        tick();
        tick();
        chk("sb_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
